// File: rtl/mem_reader_pkg.sv
// Shared types and defaults for the sequential memory stream reader.
package mem_reader_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} rd_state_t;

    localparam int DEPTH_DEF   = 32;
    localparam int MAX_LEN_DEF = 32;

endpackage

// File: rtl/mem_stream_reader.sv
// Walks memory upward from a base address and streams each nonzero word out
// on a valid/ready port; stops at a zero word, the memory end or MAX_LEN.
module mem_stream_reader
    import mem_reader_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    output logic [31:0]      dir,
    output logic [31:0]      datain,
    output logic             memwrites,
    output logic             memreads,
    input  logic [31:0]      dataout,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    rd_state_t        state, state_n;
    logic [31:0]      addr, addr_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic [31:0]      data_q, data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            count_q <= count_n;
            data_q  <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        count_n = count_q;
        data_n  = data_q;
        case (state)
            IDLE: begin
                if (start) begin
                    count_n = '0;
                    if (base_addr < 32'(DEPTH)) begin
                        addr_n  = base_addr;
                        state_n = FETCH;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            FETCH: begin
                if (dataout == 32'd0) begin
                    state_n = DONE;
                end else begin
                    data_n  = dataout;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    count_n = count_q + 1'b1;
                    addr_n  = addr + 32'd1;
                    // Clearing on transfer keeps out_data at 0 whenever out_valid is low.
                    data_n  = '0;
                    if (count_n == CNT_W'(MAX_LEN) || addr_n == 32'(DEPTH))
                        state_n = DONE;
                    else
                        state_n = FETCH;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign memreads  = (state == FETCH);
    assign dir       = memreads ? addr : 32'd0;
    assign datain    = 32'd0;
    assign memwrites = 1'b0;
    assign out_valid = (state == SEND);
    assign out_data  = data_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign count     = count_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: memory array model, queue-based expected stream,
// per-cycle compare process and directed cycle/word checks.
module tb_mem_stream_reader;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready;
    logic [31:0] base_addr;
    logic [31:0] dir, datain, dataout, out_data;
    logic        memwrites, memreads, out_valid, busy, done;
    logic [5:0]  count;

    logic        start_l, ready_l;
    logic [31:0] base_l;
    logic [31:0] dir_l, datain_l, dataout_l, data_l;
    logic        memwrites_l, memreads_l, valid_l, busy_l, done_l;
    logic [5:0]  count_l;

    logic [31:0] mem [DEPTH];
    logic [31:0] str [13];

    assign dataout   = (dir   < 32'(DEPTH)) ? mem[dir[4:0]]   : 32'hDEAD_BEEF;
    assign dataout_l = (dir_l < 32'(DEPTH)) ? mem[dir_l[4:0]] : 32'hDEAD_BEEF;

    mem_stream_reader #(.DEPTH(DEPTH), .MAX_LEN(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .dir(dir), .datain(datain), .memwrites(memwrites), .memreads(memreads),
        .dataout(dataout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .count(count)
    );

    mem_stream_reader #(.DEPTH(DEPTH), .MAX_LEN(4), .CNT_W(6)) u_lim (
        .clk(clk), .rst(rst), .start(start_l), .base_addr(base_l),
        .dir(dir_l), .datain(datain_l), .memwrites(memwrites_l), .memreads(memreads_l),
        .dataout(dataout_l), .out_data(data_l), .out_valid(valid_l),
        .out_ready(ready_l), .busy(busy_l), .done(done_l), .count(count_l)
    );

    int vec = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    // Model: the words a run must emit, derived from memory contents at start.
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic [31:0] exp_base;
    int          idx, cyc, t0, first_v, last_v, done_rel;
    bit          mon_en, done_seen, rd_seen, prev_stall;
    logic [31:0] prev_d;

    initial begin
        cyc = 0; t0 = 0; mon_en = 0; idx = 0; prev_stall = 0;
        done_seen = 0; rd_seen = 0; first_v = -1; last_v = -1; done_rel = -1;
        exp_base = '0; prev_d = '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int rel;
        if (mon_en) begin
            rel = cyc - t0 + 1;
            chk("memwrites", 32'(memwrites), 0);
            chk("datain", datain, 0);
            if (memreads) begin
                rd_seen = 1;
                chk("dir", dir, exp_base + 32'(idx));
                chk("dir_range", 32'(dir < 32'(DEPTH)), 1);
            end else begin
                chk("dir_idle", dir, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", out_data, prev_d);
            end
            if (out_valid) begin
                if (first_v < 0) first_v = rel;
                last_v = rel;
                chk("out_data", out_data, (idx < exp_q.size()) ? exp_q[idx] : 32'hFFFF_FFFF);
                prev_stall = !out_ready;
                prev_d = out_data;
                if (out_ready) begin
                    got_q.push_back(out_data);
                    idx++;
                end
            end else begin
                chk("out_data_idle", out_data, 0);
                prev_stall = 0;
            end
            if (done) begin
                done_seen = 1;
                done_rel = rel;
                chk("done_words", 32'(idx), 32'(exp_q.size()));
                chk("done_count", 32'(count), 32'(exp_q.size()));
            end
        end
    end

    logic [31:0] lim_q [$];
    bit          lim_rd4;
    initial lim_rd4 = 0;
    always @(negedge clk) begin
        if (valid_l && ready_l) lim_q.push_back(data_l);
        if (memreads_l && dir_l == 32'd4) lim_rd4 = 1;
    end

    // mode 0: ready held 1; 1: ready toggles; 2: start pulse mid-run; 3: reset at word 5
    task automatic run(input logic [31:0] base, input int mode);
        bit pulsed, aborted;
        pulsed = 0; aborted = 0;
        exp_q.delete(); got_q.delete();
        if (base < 32'(DEPTH))
            for (int a = int'(base); a < DEPTH && exp_q.size() < 32; a++) begin
                if (mem[a] == 32'd0) break;
                exp_q.push_back(mem[a]);
            end
        idx = 0; exp_base = base; first_v = -1; last_v = -1; done_rel = -1;
        done_seen = 0; rd_seen = 0; prev_stall = 0; mon_en = 1;
        base_addr = base; start = 1; out_ready = 1;
        @(posedge clk); #1;
        t0 = cyc; start = 0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            out_ready = (mode == 1) ? ~c[0] : 1'b1;
            start = 0; base_addr = base;
            if (mode == 2 && idx == 3 && !pulsed) begin
                start = 1; base_addr = 32'd5; pulsed = 1;
            end
            if (mode == 3 && out_valid && idx == 5) begin
                mon_en = 0; rst = 1;
                @(posedge clk); #1;
                rst = 0;
                chk("rst_dir", dir, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_valid", 32'(out_valid), 0);
                chk("rst_memreads", 32'(memreads), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_count", 32'(count), 0);
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 0; out_ready = 1; mon_en = 0;
        if (!aborted && !done_seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        str[0] = 65;  str[1] = 110; str[2] = 103; str[3] = 101; str[4] = 108;
        str[5] = 32;  str[6] = 77;  str[7] = 101; str[8] = 114; str[9] = 99;
        str[10] = 97; str[11] = 100; str[12] = 111;
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < 13) ? str[i] : 32'd0;
        rst = 1; start = 0; base_addr = 0; out_ready = 1;
        start_l = 0; base_l = 0; ready_l = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dir", dir, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_memreads", 32'(memreads), 0);
        rst = 0;
        @(posedge clk); #1;

        // full string, ready held high
        run(0, 0);
        chk("full_words", 32'(got_q.size()), 13);
        chk("full_w0", got_q.size() > 0 ? got_q[0] : 32'hFFFF_FFFF, 65);
        chk("full_w12", got_q.size() > 12 ? got_q[12] : 32'hFFFF_FFFF, 111);
        chk("full_first_valid", 32'(first_v), 2);
        chk("full_last_valid", 32'(last_v), 26);
        chk("full_done_cycle", 32'(done_rel), 28);
        chk("full_count", 32'(count), 13);
        repeat (2) @(posedge clk); #1;
        chk("full_count_hold", 32'(count), 13);

        // backpressure
        run(0, 1);
        chk("bp_words", 32'(got_q.size()), 13);
        for (int i = 0; i < 13 && i < got_q.size(); i++) chk("bp_word", got_q[i], str[i]);
        chk("bp_done_late", 32'(done_rel > 28), 1);

        // length limit on the MAX_LEN=4 instance
        base_l = 0; start_l = 1;
        @(posedge clk); #1;
        start_l = 0;
        for (int c = 0; c < 100 && !done_l; c++) begin @(posedge clk); #1; end
        chk("lim_done", 32'(done_l), 1);
        chk("lim_words", 32'(lim_q.size()), 4);
        for (int i = 0; i < 4 && i < lim_q.size(); i++) chk("lim_word", lim_q[i], str[i]);
        chk("lim_count", 32'(count_l), 4);
        chk("lim_no_addr4", 32'(lim_rd4), 0);
        @(posedge clk); #1;

        // memory end
        mem[30] = 72; mem[31] = 105;
        run(30, 0);
        chk("end_words", 32'(got_q.size()), 2);
        chk("end_count", 32'(count), 2);

        // bad base
        run(40, 0);
        chk("bad_done_cycle", 32'(done_rel), 1);
        chk("bad_count", 32'(count), 0);
        chk("bad_no_reads", 32'(rd_seen), 0);

        // start while busy ignored
        run(0, 2);
        chk("ctl_words", 32'(got_q.size()), 13);
        chk("ctl_count", 32'(count), 13);

        // reset during SEND of word 5, then replay
        run(0, 3);
        chk("rst_words_before", 32'(got_q.size()), 5);
        @(posedge clk); #1;
        run(0, 0);
        chk("replay_w0", got_q.size() > 0 ? got_q[0] : 32'hFFFF_FFFF, 65);
        chk("replay_words", 32'(got_q.size()), 13);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Sequential read initiator for the data memory `Mem`. On `start` it walks memory upward from a base address and issues one combinational read per word. Each captured word goes out on a valid/ready stream, for example to a UART transmitter that prints the stored ASCII string. The walk stops at a zero word, at the memory end, or at a length limit.

## Interface
- `DEPTH`, 32: number of words in the attached memory.
- `MAX_LEN`, 32: maximum words emitted per run (1..DEPTH).
- `CNT_W`, 6: width of `count`; must hold the value MAX_LEN.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `base_addr`, in, 32: first word address; captured with `start`.
- `dir`, out, 32: memory word address.
- `datain`, out, 32: memory write data; constant 0.
- `memwrites`, out, 1: constant 0 (the block never writes).
- `memreads`, out, 1: read strobe; high only in FETCH.
- `dataout`, in, 32: memory read data, valid in the same cycle as `memreads`.
- `out_data`, out, 32: stream word.
- `out_valid`, out, 1: stream word valid.
- `out_ready`, in, 1: sink accepts the word.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at the end of a run.
- `count`, out, CNT_W: words transferred in the current or last run.

## Operation
- The FSM has four states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - `start`=1 with `base_addr` < DEPTH: latch `addr`=base_addr, clear `count`, go to FETCH.
  - `start`=1 with `base_addr` ≥ DEPTH: clear `count`, go to DONE.
- FETCH:
  - Drive `dir`=addr and `memreads`=1.
  - If `dataout`==0, go to DONE; nothing is emitted.
  - Otherwise register `dataout` into `out_data` and go to SEND.
- SEND:
  - Hold `out_valid`=1 and keep `out_data` stable until `out_ready`=1 at a rising edge.
  - On that transfer, increment `count` and `addr`.
  - If the new `count`==MAX_LEN or the new `addr`==DEPTH, go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then go to IDLE. `count` holds its value until the next accepted `start`.
- `start` while `busy` is ignored. It is not queued.
- `addr` is internal, 32 bits wide. It never wraps: reaching DEPTH ends the run.
- `dir` is 0 outside FETCH. `out_data` is 0 when `out_valid`=0.

## Timing
- Reset values: state IDLE; `dir`, `datain`, `out_data`, and `count` all 0; `memwrites`, `memreads`, `out_valid`, `busy`, and `done` all 0.
- Reset asserted mid-run returns the block to the reset state at the next edge. Any pending stream word is dropped; `done` is not pulsed.
- With `start` sampled at edge of cycle 0:
  - FETCH of word k occurs in cycle 1+2k (when `out_ready` is held 1).
  - The first `out_valid` is in cycle 2.
  - Throughput is one word per 2 cycles; each cycle of `out_ready`=0 adds one cycle.
- `done` occurs in the cycle after the final FETCH (zero word) or after the final transfer (limit or memory end).
- `out_valid` never drops without a transfer except on `rst`.

## Structure
- Package `mem_reader_pkg` holds:
  - the state enum `rd_state_t` {IDLE, FETCH, SEND, DONE};
  - defaults `DEPTH_DEF`=32 and `MAX_LEN_DEF`=32.
- The block is a single module with no sub-module. The bench instantiates `Mem` as the memory model and preloads it as each test specifies.

## Test plan
- **Full string:** memory 0..12 = 65,110,103,101,108,32,77,101,114,99,97,100,111, address 13 = 0. Base 0, `out_ready`=1.
  - Required: 13 words in that order, with `out_valid` in cycles 2,4,…,26.
  - FETCH of address 13 in cycle 27; `done` in cycle 28; `count`=13; `memwrites` 0 throughout.
- **Backpressure:** same memory, `out_ready` toggling 1,0,1,0.
  - Required: same 13 words, none duplicated or lost.
  - `out_data` stable while stalled; `done` later than cycle 28.
- **Length limit:** MAX_LEN=4, base 0. Required: words 65,110,103,101; `count`=4; address 4 never read.
- **Memory end and bad base:**
  - Base 30, addresses 30 and 31 nonzero: two words, `count`=2, address 32 never driven.
  - Base 40: `done` one cycle after `start`, `count`=0, no `memreads`.
- **Control:**
  - `start` pulsed at word 3 has no effect.
  - `rst` asserted during SEND of word 5: next cycle all outputs are 0 and state is IDLE.
  - A new `start` at base 0 then replays from 65.
